// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants for the register-file writeback path.
//   REG_ADDR_WIDTH / REG_DATA_WIDTH : default register-file geometry
//   ZERO_REG                        : hard-wired zero register (x0)
//   REQ_ALU / REQ_MULDIV            : requester slot indices on the write arbiter
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int REQ_ALU    = 0;
    localparam int REQ_MULDIV = 1;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// round_robin_arbiter
// Round-robin grant generator. It owns the last_grant pointer. The search starts
// one slot past the most recent winner.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   synchronous active-low reset; also forces grant to zero while low
//   request  in   N  per-requester request lines
//   enable   in   when 0, nothing is granted and the pointer holds
//   grant    out  N  one-hot or zero, combinational
module round_robin_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] request,
    input  logic         enable,
    output logic [N-1:0] grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;
    logic [N-1:0]     grant_d;
    logic             found;

    // Walk the slots in priority order: offset 1 from the last winner first, and
    // offset N (the last winner itself) last. The first requesting slot wins.
    always_comb begin
        grant_d      = '0;
        last_grant_d = last_grant_q;
        found        = 1'b0;
        if (reset_n && enable) begin
            for (int off = 1; off <= N; off++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && request[i] && (i == (int'(last_grant_q) + off) % N)) begin
                        grant_d[i]   = 1'b1;
                        last_grant_d = IDX_W'(i);
                        found        = 1'b1;
                    end
                end
            end
        end
    end

    assign grant = grant_d;

    // Resetting the pointer to the last slot gives requester 0 first priority.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_grant_q <= IDX_W'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port among NUM_REQ writeback sources.
// Each source uses a valid/ready handshake, and a round-robin arbiter chooses the winner.
// The winner's write is registered one cycle before it reaches RegisterFile.
// Writes to x0 are accepted but dropped. A busy scoreboard tracks destinations that
// the issue stage has claimed and that are not yet written back.
// Ports:
//   clock, reset_n       clock and synchronous active-low reset
//   stall                blocks all grants this cycle
//   req_valid            NUM_REQ             per-requester write valid
//   req_address          NUM_REQ*ADDR_WIDTH  packed destinations, slice i = requester i
//   req_data             NUM_REQ*DATA_WIDTH  packed write data
//   req_ready            NUM_REQ             one-hot acceptance, combinational
//   reserve_valid/_address                   issue-stage destination claim
//   write_enable/_address/_data              registered RegisterFile write port
//   busy_mask            2**ADDR_WIDTH       outstanding-write flags, bit 0 always 0
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          reserve_valid,
    input  logic [ADDR_WIDTH-1:0]         reserve_address,
    output logic                          write_enable,
    output logic [ADDR_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [2**ADDR_WIDTH-1:0]      busy_mask
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REQ-1:0]       grant;
    logic [ADDR_WIDTH-1:0]    sel_address;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     any_grant;

    logic                     write_enable_q,  write_enable_d;
    logic [ADDR_WIDTH-1:0]    write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0]    write_data_q,    write_data_d;
    logic [2**ADDR_WIDTH-1:0] busy_q,          busy_d;

    round_robin_arbiter #(
        .N(NUM_REQ)
    ) u_arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .request (req_valid),
        .enable  (!stall),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    // Select the granted requester's slice with a one-hot mux.
    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A grant to x0 still consumes the handshake. It raises no write, and the address
    // and data registers keep their previous contents.
    always_comb begin
        write_enable_d  = any_grant && (sel_address != ZERO_ADDR);
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        if (write_enable_d) begin
            write_address_d = sel_address;
            write_data_d    = sel_data;
        end
    end

    // The clear from the registered write is applied before the set from a reserve.
    // If both target the same register on one edge, the new claim survives.
    always_comb begin
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[write_address_q] = 1'b0;
        end
        if (reserve_valid && (reserve_address != ZERO_ADDR)) begin
            busy_d[reserve_address] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            busy_q          <= '0;
        end else begin
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            busy_q          <= busy_d;
        end
    end

    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign busy_mask     = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter with NUM_REQ=2, 5-bit addresses and 32-bit data.
// Inputs change 1 time unit after a rising edge, and outputs are sampled before the next edge.
module tb_regfile_write_arbiter;

    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clock;
    logic              reset_n;
    logic              stall;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_address;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              reserve_valid;
    logic [AW-1:0]     reserve_address;
    logic              write_enable;
    logic [AW-1:0]     write_address;
    logic [DW-1:0]     write_data;
    logic [2**AW-1:0]  busy_mask;

    int checks;
    int failures;

    regfile_write_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .req_valid       (req_valid),
        .req_address     (req_address),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .reserve_valid   (reserve_valid),
        .reserve_address (reserve_address),
        .write_enable    (write_enable),
        .write_address   (write_address),
        .write_data      (write_data),
        .busy_mask       (busy_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req_valid   = v;
        req_address = {a1, a0};
        req_data    = {d1, d0};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_req(2'b00, '0, '0, '0, '0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall = 1'b0;
        reserve_valid = 1'b0;
        reserve_address = '0;
        set_req(2'b11, 5'd3, 32'h1, 5'd4, 32'h2);
        tick();
        tick();
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b expected 0", write_enable); end
        checks++; if (write_address !== 5'd0) begin failures++; $display("[TB] FAIL reset_addr: got %0d expected 0", write_address); end
        checks++; if (write_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", write_data); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("[TB] FAIL reset_busy: got %h expected 0", busy_mask); end
        reset_n = 1'b1;
        set_req(2'b00, '0, '0, '0, '0);
        tick();
    endtask

    task automatic test_single_write();
        set_req(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0);
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL single_ready: got %b expected 01", req_ready); end
        tick();
        set_req(2'b00, '0, '0, '0, '0);
        #1;
        checks++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL single_we: got %b expected 1", write_enable); end
        checks++; if (write_address !== 5'd7) begin failures++; $display("[TB] FAIL single_addr: got %0d expected 7", write_address); end
        checks++; if (write_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_data: got %h expected deadbeef", write_data); end
        tick();
        checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL single_we_off: got %b expected 0", write_enable); end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_grant [4];
        logic [AW-1:0] exp_addr  [4];
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_addr  = '{5'd1, 5'd2, 5'd1, 5'd2};
        do_reset();
        set_req(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) set_req(2'b00, 5'd1, 32'hA1, 5'd2, 32'hB2);
            #1;
            if (k < 4) begin
                checks++; if (req_ready !== exp_grant[k]) begin failures++; $display("[TB] FAIL contend_grant%0d: got %b expected %b", k, req_ready, exp_grant[k]); end
            end
            if (k > 0) begin
                checks++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL contend_we%0d: got %b expected 1", k, write_enable); end
                checks++; if (write_address !== exp_addr[k-1]) begin failures++; $display("[TB] FAIL contend_addr%0d: got %0d expected %0d", k, write_address, exp_addr[k-1]); end
            end
            tick();
        end
    endtask

    task automatic test_x0_drop();
        // The last winner was requester 1, so a lone x0 request from requester 1 is granted.
        set_req(2'b10, 5'd1, 32'hA1, 5'd0, 32'h55);
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("[TB] FAIL x0_ready: got %b expected 10", req_ready); end
        tick();
        set_req(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
        #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL x0_we: got %b expected 0", write_enable); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL x0_next_grant: got %b expected 01", req_ready); end
        tick();
        set_req(2'b00, '0, '0, '0, '0);
        #1;
        checks++; if (write_enable !== 1'b1 || write_address !== 5'd1) begin failures++; $display("[TB] FAIL x0_after: got we=%b addr=%0d expected we=1 addr=1", write_enable, write_address); end
        tick();
    endtask

    task automatic test_stall();
        // Requester 0 was the last winner, so requester 1 is next in line.
        set_req(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL stall_ready%0d: got %b expected 00", k, req_ready); end
            checks++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL stall_we%0d: got %b expected 0", k, write_enable); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("[TB] FAIL stall_resume: got %b expected 10", req_ready); end
        tick();
        set_req(2'b00, '0, '0, '0, '0);
        #1;
        checks++; if (write_enable !== 1'b1 || write_address !== 5'd2) begin failures++; $display("[TB] FAIL stall_write: got we=%b addr=%0d expected we=1 addr=2", write_enable, write_address); end
        tick();
    endtask

    task automatic test_scoreboard();
        // cycle 0: reserve register 9
        reserve_valid = 1'b1;
        reserve_address = 5'd9;
        tick();
        // cycle 1
        reserve_valid = 1'b0;
        #1;
        checks++; if (busy_mask !== 32'h0000_0200) begin failures++; $display("[TB] FAIL sb_set: got %h expected 00000200", busy_mask); end
        tick();
        // cycle 2
        tick();
        // cycle 3: the write to 9 is accepted
        set_req(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL sb_accept: got %b expected 01", req_ready); end
        tick();
        // cycle 4: the write is on the port, but the bit is not cleared yet
        set_req(2'b00, '0, '0, '0, '0);
        #1;
        checks++; if (write_enable !== 1'b1 || write_address !== 5'd9) begin failures++; $display("[TB] FAIL sb_write: got we=%b addr=%0d expected we=1 addr=9", write_enable, write_address); end
        checks++; if (busy_mask !== 32'h0000_0200) begin failures++; $display("[TB] FAIL sb_hold: got %h expected 00000200", busy_mask); end
        tick();
        // cycle 5
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("[TB] FAIL sb_clear: got %h expected 0", busy_mask); end
        // A reserve arriving in the same cycle as the clearing write must win.
        set_req(2'b01, 5'd9, 32'h77, 5'd0, 32'h0);
        tick();
        set_req(2'b00, '0, '0, '0, '0);
        reserve_valid = 1'b1;
        reserve_address = 5'd9;
        #1;
        checks++; if (write_enable !== 1'b1 || write_address !== 5'd9) begin failures++; $display("[TB] FAIL sb_write2: got we=%b addr=%0d expected we=1 addr=9", write_enable, write_address); end
        tick();
        reserve_address = 5'd0;
        #1;
        checks++; if (busy_mask !== 32'h0000_0200) begin failures++; $display("[TB] FAIL sb_reserve_wins: got %h expected 00000200", busy_mask); end
        tick();
        reserve_valid = 1'b0;
        #1;
        checks++; if (busy_mask !== 32'h0000_0200) begin failures++; $display("[TB] FAIL sb_x0_ignored: got %h expected 00000200", busy_mask); end
    endtask

    task automatic test_reset_mid();
        // Reserve register 2 while the two requesters trade grants on registers 3 and 4.
        reserve_valid = 1'b1;
        reserve_address = 5'd2;
        set_req(2'b11, 5'd3, 32'h3333, 5'd4, 32'h4444);
        tick();
        reserve_valid = 1'b0;
        tick();
        #1;
        // The pointer now rests on requester 0, and the next winner would be requester 1.
        checks++; if (busy_mask !== 32'h0000_0204) begin failures++; $display("[TB] FAIL mid_busy_pre: got %h expected 00000204", busy_mask); end
        checks++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL mid_we_pre: got %b expected 1", write_enable); end
        reset_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL mid_ready_in_reset: got %b expected 00", req_ready); end
        tick();
        checks++; if (write_enable !== 1'b0 || write_address !== 5'd0 || write_data !== 32'h0) begin failures++; $display("[TB] FAIL mid_outputs: got we=%b addr=%0d data=%h expected 0", write_enable, write_address, write_data); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("[TB] FAIL mid_busy: got %h expected 0", busy_mask); end
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL mid_first_grant: got %b expected 01", req_ready); end
        tick();
        set_req(2'b00, '0, '0, '0, '0);
        #1;
        checks++; if (write_enable !== 1'b1 || write_address !== 5'd3 || write_data !== 32'h3333) begin failures++; $display("[TB] FAIL mid_first_write: got we=%b addr=%0d data=%h expected we=1 addr=3 data=3333", write_enable, write_address, write_data); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        $display("[TB] starting regfile_write_arbiter bench");
        test_reset();
        test_single_write();
        test_contention();
        test_x0_drop();
        test_stall();
        test_scoreboard();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (`write_address`, `write_data`, `write_enable`) between `NUM_REQ` writeback requesters, e.g. the ALU/load path and a multi-cycle multiply/divide unit. Arbitration is round-robin with per-requester valid/ready handshakes and a registered output stage. The block also keeps a busy scoreboard so the issue stage can stall on registers with outstanding writes. It sits between the writeback sources and `RegisterFile`; x0 writes are handled here.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of writeback requesters (2..4).
- `ADDR_WIDTH`, default 5: register address width.
- `DATA_WIDTH`, default 32: register data width.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  when 1, no requester is granted this cycle.
- `req_valid`  in  NUM_REQ  requester i presents a write.
- `req_address`  in  NUM_REQ*ADDR_WIDTH  packed destination; slice i belongs to requester i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `req_ready`  out  NUM_REQ  one-hot or zero; requester i is accepted this cycle.
- `reserve_valid`  in  1  issue stage claims a destination register.
- `reserve_address`  in  ADDR_WIDTH  register being claimed.
- `write_enable`  out  1  to RegisterFile.
- `write_address`  out  ADDR_WIDTH  to RegisterFile.
- `write_data`  out  DATA_WIDTH  to RegisterFile.
- `busy_mask`  out  2**ADDR_WIDTH  bit r=1: register r has an outstanding write.

## Operation
- Handshake: a transfer occurs on requester i when `req_valid[i] & req_ready[i]`.
  - `req_ready` is combinational from `req_valid`, `stall` and the pointer.
  - A requester must hold valid, address and data stable until accepted.
  - `req_valid` must not depend on `req_ready`.
- Arbitration:
  - A round-robin pointer `last_grant` (index) is kept.
  - Candidates are searched starting at `last_grant+1`, modulo `NUM_REQ`; the first valid requester is granted.
  - `last_grant` updates to the granted index only when a grant occurs.
  - With `stall=1` or no valid requester: `req_ready=0` and the pointer holds.
- Output stage:
  - On a grant, `write_address` and `write_data` register the granted slice.
  - `write_enable` registers 1 only if the granted address is nonzero.
  - Otherwise `write_enable` registers 0; address and data hold their previous values.
- x0 handling:
  - A valid request to address 0 is accepted and dropped.
  - It still counts as a grant and advances the pointer.
- Scoreboard:
  - `reserve_valid` with nonzero `reserve_address` sets that bit.
  - A registered write (`write_enable=1`) clears `busy_mask[write_address]` at the next edge.
  - If the same register is reserved and cleared at the same edge, the reserve wins and the bit stays 1.
  - Reserve of x0 is ignored; `busy_mask[0]` is constant 0.
- Reset (`reset_n=0` at an edge, including mid-operation):
  - `write_enable=0`, `write_address=0`, `write_data=0`, `busy_mask=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready=0` while `reset_n=0`.
  - Any request in flight is lost; requesters re-present after reset.

## Timing
- Latency: acceptance in cycle N produces `write_enable` in cycle N+1; RegisterFile commits at the end of N+1.
- Throughput: one write per cycle. No back-pressure from RegisterFile.
- Scoreboard clear is visible in `busy_mask` from cycle N+2 after acceptance.
- A reserve in cycle N shows in `busy_mask` at N+1.
- Fairness: a continuously valid requester waits at most `NUM_REQ-1` grants, excluding stalled cycles.

## Structure
- Shared package `regfile_pkg`:
  - constants `REG_ADDR_WIDTH=5`, `REG_DATA_WIDTH=32`, `ZERO_REG=5'd0`;
  - requester index constants `REQ_ALU=0`, `REQ_MULDIV=1`.
- Sub-module `round_robin_arbiter`:
  - parameter N;
  - inputs `clock`, `reset_n`, `request[N-1:0]`, `enable`;
  - output `grant[N-1:0]`, one-hot;
  - owns the pointer.
- Top level holds the output register stage, the x0 filter and the scoreboard.

## Test plan
- Reset then single write: req0 valid, addr 7, data 0xDEADBEEF → `req_ready[0]`=1 that cycle; next cycle `write_enable`=1, address 7, data 0xDEADBEEF; then 0.
- Contention: both valid every cycle, req0 addr 1, req1 addr 2, after reset → grants alternate 0,1,0,1; `write_address` sequence 1,2,1,2 starting one cycle later.
- x0 drop: req1 valid, addr 0, data 0x55 → `req_ready[1]`=1, `write_enable` stays 0; next contested cycle grants req0.
- Stall: both valid, `stall`=1 for 3 cycles → `req_ready`=0 and `write_enable`=0 throughout; pointer unchanged; first grant after stall is the same requester as before it.
- Scoreboard: reserve 9 at cycle 0 → `busy_mask[9]`=1 at cycle 1; write to 9 accepted at cycle 3 → bit clears at cycle 5. Reserve 9 again in the cycle `write_enable` targets 9 → bit stays 1.
- Reset mid-operation: `reset_n`=0 while both requesters valid and `busy_mask`=0x0000_0204 → next cycle all outputs 0, `busy_mask`=0; the first grant after release goes to req0.
